// File: rtl/qspi_mem_responder.sv
// QPI memory target: decodes quad read (0xEB) / quad write (0x38) from an oversampled
// sck/ce_n/sio link and turns them into single-byte accesses on a synchronous memory port.
module qspi_mem_responder #(
  parameter int AW    = 16,
  parameter int DUMMY = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck,
  input  logic          ce_n,
  input  logic [3:0]    sio_i,
  output logic [3:0]    sio_o,
  output logic          sio_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t      state;
  logic [1:0]  sck_sync;
  logic [1:0]  ce_sync;
  logic [3:0]  sio_meta;
  logic [3:0]  sio_s;
  logic        sck_d;
  logic        sck_rise;
  logic        sck_fall;
  logic        ce_hi;
  logic [3:0]  cnt;
  logic [3:0]  cmd_hi;
  logic        is_read;
  logic [23:0] addr;
  logic        nib_lo;
  logic [3:0]  wbuf;
  logic [7:0]  rbuf;
  logic        rd_pend;

  // ce_n synchronizer resets to "deselected" so busy is low out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= 2'b00;
      ce_sync  <= 2'b11;
      sio_meta <= 4'h0;
      sio_s    <= 4'h0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ce_sync  <= {ce_sync[0], ce_n};
      sio_meta <= sio_i;
      sio_s    <= sio_meta;
      sck_d    <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign sck_fall = ~sck_sync[1] & sck_d;
  assign ce_hi    = ce_sync[1];
  assign busy     = ~ce_hi;
  assign mem_addr = addr[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sio_o     <= 4'h0;
      sio_en    <= 1'b0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cnt       <= 4'h0;
      cmd_hi    <= 4'h0;
      is_read   <= 1'b0;
      addr      <= 24'h0;
      nib_lo    <= 1'b0;
      wbuf      <= 4'h0;
      rbuf      <= 8'h00;
      rd_pend   <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      rd_pend <= mem_re;
      if (rd_pend)
        rbuf <= mem_rdata;
      if (state != S_IDLE && ce_hi) begin
        // deselect aborts everything: partial write byte and in-flight prefetch are dropped
        state   <= S_IDLE;
        sio_en  <= 1'b0;
        rd_pend <= 1'b0;
        nib_lo  <= 1'b0;
        cnt     <= 4'h0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!ce_hi) begin
              state  <= S_CMD;
              cnt    <= 4'h0;
              nib_lo <= 1'b0;
            end
          end
          S_CMD: begin
            if (sck_rise) begin
              cmd_hi <= sio_s;
              cnt    <= cnt + 4'd1;
              if (cnt == 4'd1) begin
                cnt <= 4'h0;
                case ({cmd_hi, sio_s})
                  8'hEB: begin is_read <= 1'b1; state <= S_ADDR; end
                  8'h38: begin is_read <= 1'b0; state <= S_ADDR; end
                  default: state <= S_IGNORE;
                endcase
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              addr <= {addr[19:0], sio_s};
              cnt  <= cnt + 4'd1;
              if (cnt == 4'd5) begin
                cnt    <= 4'h0;
                nib_lo <= 1'b0;
                if (is_read) begin
                  mem_re <= 1'b1;
                  state  <= S_DUMMY;
                end else begin
                  state <= S_WDATA;
                end
              end
            end
          end
          S_DUMMY: begin
            if (sck_rise && cnt != 4'(DUMMY)) begin
              cnt <= cnt + 4'd1;
            end else if (sck_fall && cnt == 4'(DUMMY)) begin
              sio_en <= 1'b1;
              sio_o  <= rbuf[7:4];
              nib_lo <= 1'b1;
              state  <= S_RDATA;
            end
          end
          S_RDATA: begin
            // driving the low nibble frees the byte, so prefetch the next one right away
            if (sck_fall) begin
              if (nib_lo) begin
                sio_o  <= rbuf[3:0];
                addr   <= addr + 24'd1;
                mem_re <= 1'b1;
                nib_lo <= 1'b0;
              end else begin
                sio_o  <= rbuf[7:4];
                nib_lo <= 1'b1;
              end
            end
          end
          S_WDATA: begin
            if (mem_we)
              addr <= addr + 24'd1;
            if (sck_rise) begin
              if (!nib_lo) begin
                wbuf   <= sio_s;
                nib_lo <= 1'b1;
              end else begin
                mem_wdata <= {wbuf, sio_s};
                mem_we    <= 1'b1;
                nib_lo    <= 1'b0;
              end
            end
          end
          S_IGNORE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Bench for qspi_mem_responder: QPI initiator driver, byte-array memory and a
// transaction-level model predicting strobes and returned nibbles.
module tb_qspi_mem_responder;
  localparam int AW    = 16;
  localparam int DUMMY = 6;
  localparam int HALF  = 6;
  localparam int MSZ   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sck;
  logic          ce_n;
  logic [3:0]    sio_i;
  logic [3:0]    sio_o;
  logic          sio_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic          busy;

  int         vectors;
  int         miscompares;
  logic [7:0] dev_mem [MSZ];
  logic [7:0] ref_mem [MSZ];
  int         exp_wa[$];
  int         exp_wd[$];
  int         exp_ra[$];
  logic       rd_allowed;
  logic [7:0] wdat [4];

  qspi_mem_responder #(.AW(AW), .DUMMY(DUMMY)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .sio_i(sio_i),
    .sio_o(sio_o), .sio_en(sio_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // memory device plus per-cycle strobe checks against the model's queues
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we) begin
          dev_mem[mem_addr] = mem_wdata;
          chk("we_expected", 32'(exp_wa.size() != 0), 32'd1);
          if (exp_wa.size() != 0) begin
            chk("we_addr", 32'(mem_addr), exp_wa.pop_front());
            chk("we_data", 32'(mem_wdata), exp_wd.pop_front());
          end
        end
        if (mem_re) begin
          mem_rdata = dev_mem[mem_addr];
          chk("re_expected", 32'(exp_ra.size() != 0), 32'd1);
          if (exp_ra.size() != 0)
            chk("re_addr", 32'(mem_addr), exp_ra.pop_front());
        end
        chk("strobe_excl", 32'(mem_we & mem_re), 32'd0);
        chk("sio_en_window", 32'(sio_en & ~rd_allowed), 32'd0);
      end
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    sio_i = n;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic rd_cycle(input logic [3:0] e);
    repeat (HALF) @(negedge clk);
    chk("rd_sio_en", 32'(sio_en), 32'd1);
    chk("rd_nibble", 32'(sio_o), 32'(e));
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic tx_begin();
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_end();
    repeat (2) @(negedge clk);
    ce_n = 1'b1;
    repeat (8) @(negedge clk);
    rd_allowed = 1'b0;
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int k = 5; k >= 0; k--) send_nib(a[k*4 +: 4]);
  endtask

  task automatic rd_start(input logic [23:0] a);
    tx_begin();
    send_nib(4'hE);
    send_nib(4'hB);
    send_addr(a);
    for (int k = 0; k < DUMMY; k++) send_nib(4'($urandom));
    rd_allowed = 1'b1;
  endtask

  task automatic wr_tx(input logic [23:0] a, input int n);
    tx_begin();
    send_nib(4'h3);
    send_nib(4'h8);
    send_addr(a);
    for (int j = 0; j < n; j++) begin
      send_nib(wdat[j][7:4]);
      send_nib(wdat[j][3:0]);
    end
    tx_end();
  endtask

  // model: bytes land at (a+j) mod 2^AW, one strobe per complete byte
  task automatic model_write(input logic [23:0] a, input int n);
    for (int j = 0; j < n; j++) begin
      wdat[j] = 8'($urandom);
      exp_wa.push_back((int'(a) + j) % MSZ);
      exp_wd.push_back(int'(wdat[j]));
      ref_mem[(int'(a) + j) % MSZ] = wdat[j];
    end
    wr_tx(a, n);
  endtask

  // model: n bytes read means n+1 fetches (initial fetch plus one prefetch per byte)
  task automatic model_read(input logic [23:0] a, input int n);
    logic [7:0] b;
    exp_ra.push_back(int'(a) % MSZ);
    rd_start(a);
    for (int j = 0; j < n; j++) begin
      b = ref_mem[(int'(a) + j) % MSZ];
      exp_ra.push_back((int'(a) + j + 1) % MSZ);
      rd_cycle(b[7:4]);
      rd_cycle(b[3:0]);
    end
    tx_end();
  endtask

  initial begin
    logic [23:0] ra;
    logic [7:0]  rb;
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < MSZ; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    rst = 1'b1; sck = 1'b0; ce_n = 1'b1; sio_i = 4'h0; mem_rdata = 8'h00; rd_allowed = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_sio_o", 32'(sio_o), 32'd0);
    chk("rst_sio_en", 32'(sio_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // write A5 3C at 0x000010
    wdat[0] = 8'hA5; wdat[1] = 8'h3C;
    exp_wa.push_back(32'h10); exp_wd.push_back(32'hA5);
    exp_wa.push_back(32'h11); exp_wd.push_back(32'h3C);
    ref_mem[16] = 8'hA5; ref_mem[17] = 8'h3C;
    wr_tx(24'h000010, 2);
    chk("pin_mem_10", 32'(dev_mem[16]), 32'hA5);
    chk("pin_mem_11", 32'(dev_mem[17]), 32'h3C);
    chk("pin_we_left", 32'(exp_wa.size()), 32'd0);

    // read back with literal nibbles
    exp_ra.push_back(32'h10); exp_ra.push_back(32'h11); exp_ra.push_back(32'h12);
    rd_start(24'h000010);
    rd_cycle(4'hA); rd_cycle(4'h5); rd_cycle(4'h3); rd_cycle(4'hC);
    tx_end();
    chk("pin_re_left", 32'(exp_ra.size()), 32'd0);

    // aborted write after one nibble, then an unaffected read
    tx_begin();
    send_nib(4'h3); send_nib(4'h8);
    send_addr(24'h000020);
    send_nib(4'h7);
    tx_end();
    model_read(24'h000010, 2);

    // unknown command
    tx_begin();
    chk("busy_low_ce", 32'(busy), 32'd1);
    send_nib(4'h9); send_nib(4'hF);
    for (int k = 0; k < 10; k++) send_nib(4'($urandom));
    chk("busy_ignore", 32'(busy), 32'd1);
    tx_end();
    chk("busy_after", 32'(busy), 32'd0);

    // address wrap at 2^AW for reads and writes
    model_read(24'h00FFFF, 2);
    model_write(24'hFFFFFF, 2);
    model_read(24'h00FFFF, 2);

    // reset in the middle of the read data phase
    rb = ref_mem[16];
    exp_ra.push_back(32'h10);
    rd_start(24'h000010);
    rd_cycle(rb[7:4]);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_sio_o", 32'(sio_o), 32'd0);
    chk("mid_rst_sio_en", 32'(sio_en), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_strobes", 32'({mem_we, mem_re}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
    rd_allowed = 1'b0; ce_n = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_read(24'h000010, 1);

    // randomized traffic, biased towards the wrap boundary
    repeat (20) begin
      ra = 24'($urandom);
      if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFFF - 16'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) model_write(ra, $urandom_range(1, 4));
      else model_read(ra, $urandom_range(1, 4));
    end

    repeat (4) @(negedge clk);
    chk("we_left", 32'(exp_wa.size()), 32'd0);
    chk("re_left", 32'(exp_ra.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qspi_mem_responder.md
# qspi_mem_responder

Synthesizable QPI-mode memory responder: the target end of the quad-SPI link that the SoC's QSPI initiator drives on sck/ce_n/sio. It decodes quad read (0xEB) and quad write (0x38) transactions and turns them into byte accesses on a simple synchronous memory port. It is used for on-chip PSRAM emulation on FPGA builds and as a loop-back target in system benches. It oversamples the serial bus in the system clock domain.

## Interface

- AW, 16: memory port address width; the 24-bit bus address is truncated to AW LSBs.
- DUMMY, 6: dummy sck cycles between the last address nibble and the first read-data nibble; legal range 2..15.
- clk  in  1  system clock; all state in this domain.
- rst  in  1  asynchronous, active-high reset.
- sck  in  1  serial clock from initiator, mode 0 (idle low).
- ce_n  in  1  chip enable, active low.
- sio_i  in  4  quad data in.
- sio_o  out  4  quad data out.
- sio_en  out  1  drive enable for sio_o (high only in read-data phase).
- mem_addr  out  AW  byte address.
- mem_wdata  out  8  write byte.
- mem_we  out  1  one-clk write strobe.
- mem_re  out  1  one-clk read strobe.
- mem_rdata  in  8  read byte, valid exactly 1 clk after mem_re.
- busy  out  1  high while ce_n (synchronized) is low.

## Operation

- sck, ce_n, sio_i each pass through a 2-flop synchronizer; edges are detected on synchronized sck; all decisions use the synchronized values.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE: synchronized ce_n falling -> CMD, nibble counter cleared.
- CMD: 2 nibbles sampled on sck rising edges, high nibble first. 0xEB -> ADDR (read), 0x38 -> ADDR (write), any other -> IGNORE.
- ADDR: 6 nibbles, MSB first, into 24-bit register. After the 6th: read -> DUMMY and issue mem_re at address; write -> WDATA.
- DUMMY: count DUMMY rising edges; on the falling edge following the last dummy rising edge, sio_en=1, sio_o=rdata[7:4], -> RDATA.
- RDATA: on each sck falling edge drive next nibble (low, then high of next byte). When the low nibble is driven, address increments and mem_re fires for the next byte (prefetch); rdata latched into the shift register on the cycle after mem_re.
- WDATA: nibbles sampled on rising edges, high first; after the low nibble, mem_we pulses for 1 clk with the assembled byte at current address, then address increments.
- Address increment is modulo 2^24; mem_addr = addr[AW-1:0], so wrap at 2^AW.
- IGNORE: no strobes, sio_en=0, until ce_n high.
- Synchronized ce_n rising in any state -> IDLE same clk; sio_en=0, partial write byte discarded (no mem_we), outstanding prefetch data discarded.
- Reset (any time, including mid-transaction): state IDLE, sio_o=0, sio_en=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, counters and shift registers 0.

## Timing

- Input latency: 2 clk synchronizer + 1 clk edge detect; sio_o/sio_en update 1 clk after the detected sck falling edge, i.e. 3-4 clk after the pin edge.
- Requirement on initiator: sck high and low each >= 4 clk periods; ce_n high >= 4 clk between transactions.
- First read byte: mem_re issued 1 clk after last address nibble sampled; data needed DUMMY sck cycles later (>= 16 clk), so the 1-clk memory latency is always met.
- mem_we and mem_re never assert in the same clk; each is a single-cycle pulse.
- Throughput: one byte per 2 sck cycles in both directions.

## Test plan

- Reset: assert rst mid-RDATA -> all outputs 0 within same clk, sio_en=0; after release, state IDLE, a new transaction works.
- Quad write: ce_n low, 0x38, address 0x000010, bytes 0xA5 0x3C -> mem_we pulses at mem_addr 0x0010 wdata 0xA5, then 0x0011 wdata 0x3C; exactly two strobes.
- Quad read: memory preloaded 0x0010=0xA5, 0x0011=0x3C; 0xEB, address 0x000010, 6 dummy cycles, 4 data sck cycles -> sio_o nibbles A,5,3,C sampled by initiator on rising edges; sio_en high only during data phase.
- Abort: 0x38, address 0x000020, one data nibble then ce_n high -> no mem_we; sio_en stays 0; next read transaction unaffected.
- Unknown command 0x9F followed by 10 sck cycles -> no mem_re/mem_we, sio_en never 1, busy falls with ce_n.
- Wrap: read at 0x00FFFF for 2 bytes (AW=16) -> mem_re at 0xFFFF then 0x0000; write at 0xFFFFFF two bytes -> mem_we at 0xFFFF then 0x0000.
